// File: rtl/spi_req_arbiter_if.sv
// Bundles the requester handshake and the SPI core register port of spi_req_arbiter.
`timescale 1ns/1ps
interface spi_req_arbiter_if #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned ADDR_W = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [7:0]        rsp_data;
  logic              rsp_err;
  logic [ADDR_W-1:0] rw_addr;
  logic              wr_en;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic              rd_en;
  logic [31:0]       rd_data;
  logic              spi_irq;
  logic              busy;

  modport master (
    input  req_valid, req_data, rd_data, spi_irq,
    output req_ready, rsp_valid, rsp_data, rsp_err, rw_addr, wr_en, wr_data, wr_strb, rd_en, busy
  );

  modport slave (
    output req_valid, req_data, rd_data, spi_irq,
    input  req_ready, rsp_valid, rsp_data, rsp_err, rw_addr, wr_en, wr_data, wr_strb, rd_en, busy
  );
endinterface

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter that runs one SPI byte transfer per grant through the core's register port
// (select CS, write TX, wait irq, read RX, deselect) and returns the RX byte or a timeout error.
`timescale 1ns/1ps
module spi_req_arbiter #(
  parameter int unsigned        NREQ      = 4,
  parameter int unsigned        ADDR_W    = 4,
  parameter logic [ADDR_W-1:0]  ADDR_CTRL = ADDR_W'('h0),
  parameter logic [ADDR_W-1:0]  ADDR_TX   = ADDR_W'('h4),
  parameter logic [ADDR_W-1:0]  ADDR_RX   = ADDR_W'('h8),
  parameter int unsigned        TIMEOUT   = 1024
) (
  input logic               apb_clk,
  input logic               apb_rst,
  spi_req_arbiter_if.master bus
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle, StSel, StWrTx, StWaitIrq, StRdReq, StRdCap, StDesel, StResp
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   grant_q, grant_d;
  logic [IdxW-1:0]   rr_q, rr_d;
  logic [7:0]        byte_q, byte_d;
  logic [7:0]        rx_q, rx_d;
  logic              err_q, err_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [NREQ-1:0]   req_ready_q, req_ready_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [7:0]        rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0] rw_addr_q, rw_addr_d;
  logic              wr_en_q, wr_en_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [3:0]        wr_strb_q, wr_strb_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;

  logic [IdxW-1:0]   pick;
  logic [IdxW-1:0]   cand;
  logic              found;
  logic              unused_rd;

  assign unused_rd = ^bus.rd_data[31:8];

  // First requester at or after the round-robin pointer, wrapping at NREQ-1.
  always_comb begin
    pick  = rr_q;
    cand  = rr_q;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IdxW'((32'(rr_q) + k) % NREQ);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    byte_d  = byte_q;
    rx_d    = rx_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (|bus.req_valid) begin
          grant_d = pick;
          byte_d  = bus.req_data[8*pick +: 8];
          rx_d    = 8'h00;
          err_d   = 1'b0;
          state_d = StSel;
        end
      end
      StSel: state_d = StWrTx;
      StWrTx: begin
        cnt_d   = '0;
        state_d = StWaitIrq;
      end
      StWaitIrq: begin
        if (bus.spi_irq) begin
          state_d = StRdReq;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StDesel;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRdReq: state_d = StRdCap;
      StRdCap: begin
        rx_d    = bus.rd_data[7:0];
        state_d = StDesel;
      end
      StDesel: state_d = StResp;
      StResp: begin
        rr_d    = (grant_q == IdxW'(NREQ - 1)) ? '0 : grant_q + IdxW'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_data_d  = 8'h00;
    rsp_err_d   = 1'b0;
    rw_addr_d   = '0;
    wr_en_d     = 1'b0;
    wr_data_d   = 32'h0;
    rd_en_d     = 1'b0;
    busy_d      = (state_d != StIdle);
    unique case (state_d)
      StSel: begin
        req_ready_d[grant_d] = 1'b1;
        wr_en_d   = 1'b1;
        rw_addr_d = ADDR_CTRL;
        wr_data_d = 32'(1) << grant_d;
      end
      StWrTx: begin
        wr_en_d   = 1'b1;
        rw_addr_d = ADDR_TX;
        wr_data_d = {24'h0, byte_q};
      end
      StRdReq: begin
        rd_en_d   = 1'b1;
        rw_addr_d = ADDR_RX;
      end
      StDesel: begin
        wr_en_d   = 1'b1;
        rw_addr_d = ADDR_CTRL;
      end
      StResp: begin
        rsp_valid_d[grant_q] = 1'b1;
        rsp_data_d = rx_q;
        rsp_err_d  = err_q;
      end
      default: ;
    endcase
    wr_strb_d = wr_en_d ? 4'b0001 : 4'b0000;
  end

  always_ff @(posedge apb_clk or negedge apb_rst) begin
    if (!apb_rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      rr_q        <= '0;
      byte_q      <= 8'h00;
      rx_q        <= 8'h00;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= 8'h00;
      rsp_err_q   <= 1'b0;
      rw_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= 32'h0;
      wr_strb_q   <= 4'h0;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      byte_q      <= byte_d;
      rx_q        <= rx_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rw_addr_q   <= rw_addr_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      wr_strb_q   <= wr_strb_d;
      rd_en_q     <= rd_en_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rw_addr   = rw_addr_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_strb   = wr_strb_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Bench for spi_req_arbiter: vector table plus hand sequences, with an inline SPI core model.
`timescale 1ns/1ps
module tb_spi_req_arbiter;

  localparam int TO = 16;

  logic clk;
  logic rst_n;

  spi_req_arbiter_if #(.NREQ(4), .ADDR_W(4)) bus ();

  spi_req_arbiter #(
    .NREQ(4), .ADDR_W(4), .ADDR_CTRL(4'h0), .ADDR_TX(4'h4), .ADDR_RX(4'h8), .TIMEOUT(TO)
  ) dut (
    .apb_clk (clk),
    .apb_rst (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] data;
    bit          hold;
    int          dly;    // irq delay after TX write, -1 = never
    logic [7:0]  rx;
    int          grant;
    bit          err;
  } vec_t;

  typedef struct {
    int         grant;
    logic [7:0] data;
    bit         err;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_ctl"}, {bus.busy, bus.wr_en, bus.rd_en, bus.rsp_err, bus.wr_strb}, 0);
    chk({name, "_hs"}, {bus.req_ready, bus.rsp_valid, bus.rsp_data}, 0);
    chk({name, "_bus"}, {bus.rw_addr, bus.wr_data}, 0);
  endtask

  task automatic run_txn(input logic [3:0] mask, input logic [31:0] data, input bit hold,
                         input int dly, input logic [7:0] rx, input int g, input bit err);
    exp_t        e;
    exp_t        got;
    logic [31:0] ctrl[2];
    int          n_ctrl = 0;
    int          n_rd = 0;
    logic [7:0]  txb = 8'h00;
    int          irq_cnt = 0;
    int          tx_at = 0;
    int          desel_at = 0;
    int          cyc = 0;
    bit          done = 0;
    ctrl[0] = '1;
    ctrl[1] = '1;
    e.grant = g;
    e.data  = err ? 8'h00 : rx;
    e.err   = err;
    sb.push_back(e);
    bus.req_valid = mask;
    bus.req_data  = data;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (irq_cnt > 0) begin
        irq_cnt--;
        if (irq_cnt == 0) bus.spi_irq = 1'b1;
      end
      if (bus.req_ready != 0) begin
        chk("req_ready", bus.req_ready, 64'(1) << g);
        if (!hold) bus.req_valid = 4'b0000;
      end
      if (bus.wr_en || bus.rd_en) chk("wr_rd_excl", bus.wr_en & bus.rd_en, 0);
      if (bus.wr_en) begin
        chk("wr_strb", bus.wr_strb, 4'b0001);
        if (bus.rw_addr == 4'h0) begin
          if (n_ctrl < 2) ctrl[n_ctrl] = bus.wr_data;
          n_ctrl++;
          if (bus.wr_data == 0) desel_at = cyc;
        end else if (bus.rw_addr == 4'h4) begin
          txb   = bus.wr_data[7:0];
          chk("tx_upper", bus.wr_data[31:8], 0);
          tx_at = cyc;
          if (dly == 0) bus.spi_irq = 1'b1;
          else if (dly > 0) irq_cnt = dly;
        end else begin
          chk("wr_addr", bus.rw_addr, 0);
        end
      end
      if (bus.rd_en) begin
        chk("rd_addr", bus.rw_addr, 4'h8);
        n_rd++;
        bus.rd_data = {24'hABCDEF, rx};
        bus.spi_irq = 1'b0;
      end
      if (bus.rsp_valid != 0) begin
        done = 1;
        if (sb.size() == 0) begin
          chk("unexpected_rsp", bus.rsp_valid, 0);
        end else begin
          got = sb.pop_front();
          chk("rsp_valid", bus.rsp_valid, 64'(1) << got.grant);
          chk("rsp_data", bus.rsp_data, got.data);
          chk("rsp_err", bus.rsp_err, got.err);
        end
      end
    end
    if (!done) chk("rsp_never_arrived", 0, 1);
    chk("ctrl_count", n_ctrl, 2);
    chk("ctrl_sel", ctrl[0], 64'(1) << g);
    chk("ctrl_desel", ctrl[1], 0);
    chk("tx_byte", txb, data[8*g +: 8]);
    chk("rd_count", n_rd, err ? 0 : 1);
    if (err) chk("wait_cycles", desel_at - tx_at, TO + 1);
    bus.spi_irq = 1'b0;
    bus.rd_data = 32'h0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bit seen;
    //         mask     data          hold dly  rx     grant err
    vecs[0]  = '{4'b1111, 32'h44332211, 1, 1,  8'h11, 0, 0};
    vecs[1]  = '{4'b1111, 32'h44332211, 1, 2,  8'h22, 1, 0};
    vecs[2]  = '{4'b1111, 32'h44332211, 1, 0,  8'h33, 2, 0};
    vecs[3]  = '{4'b1111, 32'h44332211, 1, 4,  8'h44, 3, 0};
    vecs[4]  = '{4'b1111, 32'h44332211, 0, 1,  8'h55, 0, 0};
    vecs[5]  = '{4'b0001, 32'h000000A5, 0, 3,  8'h3C, 0, 0};
    vecs[6]  = '{4'b0010, 32'h0000C300, 0, 2,  8'h96, 1, 0};
    vecs[7]  = '{4'b0011, 32'h00007E81, 0, 1,  8'h01, 0, 0};
    vecs[8]  = '{4'b0011, 32'h00007E81, 0, 1,  8'hFE, 1, 0};
    vecs[9]  = '{4'b1000, 32'hD2000000, 0, -1, 8'h77, 3, 1};
    vecs[10] = '{4'b0100, 32'h005A0000, 0, 5,  8'h5A, 2, 0};

    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rd_data   = '0;
    bus.spi_irq   = 1'b0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++)
      run_txn(vecs[i].mask, vecs[i].data, vecs[i].hold, vecs[i].dly, vecs[i].rx,
              vecs[i].grant, vecs[i].err);

    // irq while idle must not start any bus activity
    bus.spi_irq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_irq_quiet", {bus.busy, bus.wr_en, bus.rd_en, bus.req_ready}, 0);
    end
    bus.spi_irq = 1'b0;
    run_txn(4'b1000, 32'hE7000000, 0, 2, 8'hC8, 3, 0);

    // Move pointer to 1, then reset mid-wait and expect service from pointer 0
    run_txn(4'b0001, 32'h00000042, 0, 1, 8'h24, 0, 0);
    bus.req_valid = 4'b0010;
    bus.req_data  = 32'h00009900;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.req_ready != 0) begin
        seen = 1;
        chk("rst_seq_ready", bus.req_ready, 4'b0010);
        bus.req_valid = 4'b0000;
      end
    end
    if (!seen) chk("rst_seq_ready_seen", 0, 1);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.wr_en && bus.rw_addr == 4'h4) seen = 1;
    end
    if (!seen) chk("rst_seq_tx_seen", 0, 1);
    repeat (3) @(negedge clk);
    chk("rst_seq_busy_before", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk_quiet("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_quiet("rst_after");
    run_txn(4'b1111, 32'h0D0C0B0A, 0, 1, 8'h6B, 0, 0);

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
